// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: opcodes, FSM states,
// byte-enable constants and small decode helpers.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic size_e access_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge bus between the load/store unit (master) and the
// variable-latency data memory (slave).
interface mem_access_unit_if;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Combinational lane select and sign/zero extension of load data; shared
// with the WB stage.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [5:0]  opcode,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ext = rdata;
    case (opcode)
      OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext = {24'h0, byte_sel};
      OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext = {16'h0, half_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: decodes the M-stage instruction, runs one
// req/ack transaction per access and stalls the pipeline while it is open.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter logic [31:0] DM_BASE = 32'h0000_0000,
  parameter logic [31:0] DM_SIZE = 32'h0000_3000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrM,
  input  logic [31:0] ALUoutM,
  input  logic [31:0] rtM,
  input  logic        intclr,
  output logic [31:0] DMoutM,
  output logic        stallM,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_dbe,
  mem_access_unit_if.master dm
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  logic [5:0]  opcode;
  logic        ld;
  logic        st;
  size_e       size;
  logic        misalign;
  logic        out_of_window;
  logic        addr_err;
  logic        issue;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] ext_data;

  state_e      state_q;
  logic [7:0]  wait_cnt_q;
  logic        req_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [5:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] dmout_q;
  logic        dbe_q;

  wire unused_instr_bits = ^instrM[25:0];

  assign opcode = instrM[31:26];
  assign ld     = is_load(opcode);
  assign st     = is_store(opcode);
  assign size   = access_size(opcode);

  always_comb begin
    misalign = 1'b0;
    case (size)
      SZ_HALF: misalign = ALUoutM[0];
      SZ_WORD: misalign = (ALUoutM[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
  end

  // Offset from the base makes the window test a single unsigned compare.
  assign out_of_window = ((ALUoutM - DM_BASE) >= DM_SIZE);
  assign addr_err      = (ld || st) && (misalign || out_of_window);

  assign exc_adel = (state_q == IDLE) && ld && addr_err;
  assign exc_ades = (state_q == IDLE) && st && addr_err;
  assign issue    = (state_q == IDLE) && (ld || st) && !addr_err && !intclr;
  assign stallM   = issue || (state_q == BUSY);

  always_comb begin
    be_fmt    = BE_ALL;
    wdata_fmt = rtM;
    case (size)
      SZ_BYTE: begin
        be_fmt    = BE_BYTE0 << ALUoutM[1:0];
        wdata_fmt = {4{rtM[7:0]}};
      end
      SZ_HALF: begin
        be_fmt    = ALUoutM[1] ? BE_HI_HALF : BE_LO_HALF;
        wdata_fmt = {2{rtM[15:0]}};
      end
      default: begin
        be_fmt    = BE_ALL;
        wdata_fmt = rtM;
      end
    endcase
  end

  load_extend u_load_extend (
    .rdata   (dm.dm_rdata),
    .addr_lo (addr_lo_q),
    .opcode  (op_q),
    .ext     (ext_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= BE_NONE;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      op_q       <= 6'h0;
      addr_lo_q  <= 2'b00;
      dmout_q    <= 32'h0;
      dbe_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            req_q      <= 1'b1;
            we_q       <= st;
            be_q       <= st ? be_fmt : BE_ALL;
            addr_q     <= {ALUoutM[31:2], 2'b00};
            wdata_q    <= st ? wdata_fmt : 32'h0;
            op_q       <= opcode;
            addr_lo_q  <= ALUoutM[1:0];
            wait_cnt_q <= 8'd1;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          // An ack arriving in the last allowed cycle still wins over timeout.
          if (dm.dm_ack) begin
            req_q   <= 1'b0;
            if (is_load(op_q)) begin
              dmout_q <= ext_data;
            end
            state_q <= DONE;
          end else if (wait_cnt_q == TIMEOUT_CNT) begin
            req_q   <= 1'b0;
            dmout_q <= 32'h0;
            dbe_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        DONE: begin
          dbe_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          dbe_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dm.dm_req   = req_q;
  assign dm.dm_we    = we_q;
  assign dm.dm_be    = be_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;
  assign DMoutM      = dmout_q;
  assign exc_dbe     = dbe_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; inputs change and outputs are sampled
// on the falling clock edge.
module tb_mem_access_unit;

  localparam logic [5:0] T_LB  = 6'h20;
  localparam logic [5:0] T_LH  = 6'h21;
  localparam logic [5:0] T_LW  = 6'h23;
  localparam logic [5:0] T_LBU = 6'h24;
  localparam logic [5:0] T_LHU = 6'h25;
  localparam logic [5:0] T_SB  = 6'h28;
  localparam logic [5:0] T_SH  = 6'h29;
  localparam logic [5:0] T_SW  = 6'h2B;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrM;
  logic [31:0] ALUoutM;
  logic [31:0] rtM;
  logic        intclr;
  logic [31:0] DMoutM;
  logic        stallM;
  logic        exc_adel;
  logic        exc_ades;
  logic        exc_dbe;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mem_access_unit_if dm_bus ();

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .instrM   (instrM),
    .ALUoutM  (ALUoutM),
    .rtM      (rtM),
    .intclr   (intclr),
    .DMoutM   (DMoutM),
    .stallM   (stallM),
    .exc_adel (exc_adel),
    .exc_ades (exc_ades),
    .exc_dbe  (exc_dbe),
    .dm       (dm_bus)
  );

  task automatic set_inst(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt);
    instrM  = {op, 26'h0};
    ALUoutM = addr;
    rtM     = rt;
  endtask

  task automatic test_reset();
    reset = 1'b0; instrM = 32'h0; ALUoutM = 32'h0; rtM = 32'h0; intclr = 1'b0;
    dm_bus.dm_ack = 1'b0; dm_bus.dm_rdata = 32'h0;
    repeat (2) @(negedge clk);
    total_cnt++; if (dm_bus.dm_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", dm_bus.dm_req); else pass_cnt++;
    total_cnt++; if (dm_bus.dm_be !== 4'h0) $display("FAIL reset_be: got %h want 0", dm_bus.dm_be); else pass_cnt++;
    total_cnt++; if (dm_bus.dm_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", dm_bus.dm_addr); else pass_cnt++;
    total_cnt++; if (DMoutM !== 32'h0) $display("FAIL reset_dmout: got %h want 0", DMoutM); else pass_cnt++;
    total_cnt++; if (exc_dbe !== 1'b0) $display("FAIL reset_dbe: got %0b want 0", exc_dbe); else pass_cnt++;
    total_cnt++; if (stallM !== 1'b0) $display("FAIL reset_stall: got %0b want 0", stallM); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    $display("txn reset done");
  endtask

  task automatic test_store_word();
    set_inst(T_SW, 32'h100, 32'h1234_5678);
    #1;
    total_cnt++; if (stallM !== 1'b1) $display("FAIL sw_stall_c0: got %0b want 1", stallM); else pass_cnt++;
    total_cnt++; if (dm_bus.dm_req !== 1'b0) $display("FAIL sw_req_c0: got %0b want 0", dm_bus.dm_req); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (dm_bus.dm_req !== 1'b1) $display("FAIL sw_req_c1: got %0b want 1", dm_bus.dm_req); else pass_cnt++;
    total_cnt++; if (dm_bus.dm_we !== 1'b1) $display("FAIL sw_we: got %0b want 1", dm_bus.dm_we); else pass_cnt++;
    total_cnt++; if (dm_bus.dm_be !== 4'b1111) $display("FAIL sw_be: got %b want 1111", dm_bus.dm_be); else pass_cnt++;
    total_cnt++; if (dm_bus.dm_addr !== 32'h100) $display("FAIL sw_addr: got %h want 00000100", dm_bus.dm_addr); else pass_cnt++;
    total_cnt++; if (dm_bus.dm_wdata !== 32'h1234_5678) $display("FAIL sw_wdata: got %h want 12345678", dm_bus.dm_wdata); else pass_cnt++;
    total_cnt++; if (stallM !== 1'b1) $display("FAIL sw_stall_c1: got %0b want 1", stallM); else pass_cnt++;
    dm_bus.dm_ack = 1'b1;
    @(negedge clk);
    dm_bus.dm_ack = 1'b0;
    total_cnt++; if (stallM !== 1'b0) $display("FAIL sw_stall_c2: got %0b want 0", stallM); else pass_cnt++;
    total_cnt++; if (dm_bus.dm_req !== 1'b0) $display("FAIL sw_req_c2: got %0b want 0", dm_bus.dm_req); else pass_cnt++;
    total_cnt++; if (DMoutM !== 32'h0) $display("FAIL sw_dmout: got %h want 0", DMoutM); else pass_cnt++;
    instrM = 32'h0;
    @(negedge clk);
    $display("txn sw addr=00000100 data=12345678");
  endtask

  task automatic test_loads();
    logic [5:0]  ops   [6] = '{T_LB, T_LBU, T_LH, T_LHU, T_LB, T_LW};
    logic [31:0] addrs [6] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101, 32'h100};
    logic [31:0] exps  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80AA,
                               32'h0000_BBCC, 32'hFFFF_FFBB, 32'h80AA_BBCC};
    int          dly   [6] = '{1, 2, 1, 3, 1, 1};
    dm_bus.dm_rdata = 32'h80AA_BBCC;
    for (int i = 0; i < 6; i++) begin
      set_inst(ops[i], addrs[i], 32'hDEAD_BEEF);
      @(negedge clk);
      total_cnt++; if (dm_bus.dm_addr !== 32'h100) $display("FAIL ld%0d_addr: got %h want 00000100", i, dm_bus.dm_addr); else pass_cnt++;
      total_cnt++; if ({dm_bus.dm_we, dm_bus.dm_be} !== 5'b0_1111) $display("FAIL ld%0d_we_be: got %b want 01111", i, {dm_bus.dm_we, dm_bus.dm_be}); else pass_cnt++;
      for (int d = 1; d < dly[i]; d++) @(negedge clk);
      dm_bus.dm_ack = 1'b1;
      @(negedge clk);
      dm_bus.dm_ack = 1'b0;
      total_cnt++; if (DMoutM !== exps[i]) $display("FAIL ld%0d_data: got %h want %h", i, DMoutM, exps[i]); else pass_cnt++;
      total_cnt++; if (stallM !== 1'b0) $display("FAIL ld%0d_stall_done: got %0b want 0", i, stallM); else pass_cnt++;
      instrM = 32'h0;
      @(negedge clk);
      $display("txn load op=%h addr=%h data=%h", ops[i], addrs[i], DMoutM);
    end
  endtask

  task automatic test_store_formats();
    set_inst(T_SH, 32'h202, 32'h0000_BEEF);
    @(negedge clk);
    total_cnt++; if (dm_bus.dm_be !== 4'b1100) $display("FAIL sh_be: got %b want 1100", dm_bus.dm_be); else pass_cnt++;
    total_cnt++; if (dm_bus.dm_wdata !== 32'hBEEF_BEEF) $display("FAIL sh_wdata: got %h want beefbeef", dm_bus.dm_wdata); else pass_cnt++;
    total_cnt++; if (dm_bus.dm_addr !== 32'h200) $display("FAIL sh_addr: got %h want 00000200", dm_bus.dm_addr); else pass_cnt++;
    dm_bus.dm_ack = 1'b1;
    @(negedge clk);
    dm_bus.dm_ack = 1'b0;
    total_cnt++; if (DMoutM !== 32'h80AA_BBCC) $display("FAIL sh_dmout_hold: got %h want 80aabbcc", DMoutM); else pass_cnt++;
    instrM = 32'h0;
    @(negedge clk);
    $display("txn sh addr=00000202 data=0000beef");
    set_inst(T_SB, 32'h201, 32'h1234_565A);
    @(negedge clk);
    total_cnt++; if (dm_bus.dm_be !== 4'b0010) $display("FAIL sb_be: got %b want 0010", dm_bus.dm_be); else pass_cnt++;
    total_cnt++; if (dm_bus.dm_wdata !== 32'h5A5A_5A5A) $display("FAIL sb_wdata: got %h want 5a5a5a5a", dm_bus.dm_wdata); else pass_cnt++;
    dm_bus.dm_ack = 1'b1;
    @(negedge clk);
    dm_bus.dm_ack = 1'b0;
    instrM = 32'h0;
    @(negedge clk);
    $display("txn sb addr=00000201 data=1234565a");
  endtask

  task automatic test_addr_errors();
    logic [5:0]  ops   [4] = '{T_LW, T_LH, T_SW, T_SB};
    logic [31:0] addrs [4] = '{32'h102, 32'h101, 32'h3000, 32'h3000};
    logic        eadel [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      set_inst(ops[i], addrs[i], 32'h5555_5555);
      #1;
      total_cnt++; if (exc_adel !== eadel[i]) $display("FAIL err%0d_adel: got %0b want %0b", i, exc_adel, eadel[i]); else pass_cnt++;
      total_cnt++; if (exc_ades !== !eadel[i]) $display("FAIL err%0d_ades: got %0b want %0b", i, exc_ades, !eadel[i]); else pass_cnt++;
      total_cnt++; if (stallM !== 1'b0) $display("FAIL err%0d_stall: got %0b want 0", i, stallM); else pass_cnt++;
      repeat (2) begin
        @(negedge clk);
        total_cnt++; if (dm_bus.dm_req !== 1'b0) $display("FAIL err%0d_req: got %0b want 0", i, dm_bus.dm_req); else pass_cnt++;
      end
      $display("txn addr_error op=%h addr=%h", ops[i], addrs[i]);
    end
    set_inst(T_SW, 32'h100, 32'h7777_7777);
    intclr = 1'b1;
    #1;
    total_cnt++; if (stallM !== 1'b0) $display("FAIL intclr_stall: got %0b want 0", stallM); else pass_cnt++;
    total_cnt++; if (exc_ades !== 1'b0) $display("FAIL intclr_ades: got %0b want 0", exc_ades); else pass_cnt++;
    repeat (2) begin
      @(negedge clk);
      total_cnt++; if (dm_bus.dm_req !== 1'b0) $display("FAIL intclr_req: got %0b want 0", dm_bus.dm_req); else pass_cnt++;
    end
    intclr = 1'b0;
    instrM = 32'h0;
    @(negedge clk);
    $display("txn sw suppressed by intclr");
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    set_inst(T_LW, 32'h100, 32'h0);
    @(negedge clk);
    while (dm_bus.dm_req === 1'b1 && req_cycles < 20) begin
      req_cycles++;
      @(negedge clk);
    end
    total_cnt++; if (req_cycles !== 4) $display("FAIL to_req_cycles: got %0d want 4", req_cycles); else pass_cnt++;
    total_cnt++; if (exc_dbe !== 1'b1) $display("FAIL to_dbe_done: got %0b want 1", exc_dbe); else pass_cnt++;
    total_cnt++; if (stallM !== 1'b0) $display("FAIL to_stall_done: got %0b want 0", stallM); else pass_cnt++;
    total_cnt++; if (DMoutM !== 32'h0) $display("FAIL to_dmout: got %h want 0", DMoutM); else pass_cnt++;
    instrM = 32'h0;
    dm_bus.dm_rdata = 32'h1357_9BDF;
    dm_bus.dm_ack = 1'b1;
    @(negedge clk);
    total_cnt++; if (exc_dbe !== 1'b0) $display("FAIL to_dbe_pulse: got %0b want 0", exc_dbe); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (dm_bus.dm_req !== 1'b0) $display("FAIL to_late_ack_req: got %0b want 0", dm_bus.dm_req); else pass_cnt++;
    total_cnt++; if (DMoutM !== 32'h0) $display("FAIL to_late_ack_dmout: got %h want 0", DMoutM); else pass_cnt++;
    dm_bus.dm_ack = 1'b0;
    $display("txn lw timeout after %0d request cycles", req_cycles);
  endtask

  task automatic test_reset_mid_busy();
    dm_bus.dm_rdata = 32'hCAFE_F00D;
    set_inst(T_LW, 32'h104, 32'h0);
    @(negedge clk);
    dm_bus.dm_ack = 1'b1;
    @(negedge clk);
    dm_bus.dm_ack = 1'b0;
    total_cnt++; if (DMoutM !== 32'hCAFE_F00D) $display("FAIL rst_pre_load: got %h want cafef00d", DMoutM); else pass_cnt++;
    instrM = 32'h0;
    @(negedge clk);
    set_inst(T_LW, 32'h104, 32'h0);
    @(negedge clk);
    total_cnt++; if (dm_bus.dm_req !== 1'b1) $display("FAIL rst_busy_req: got %0b want 1", dm_bus.dm_req); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++; if (dm_bus.dm_req !== 1'b0) $display("FAIL rst_async_req: got %0b want 0", dm_bus.dm_req); else pass_cnt++;
    total_cnt++; if (DMoutM !== 32'h0) $display("FAIL rst_async_dmout: got %h want 0", DMoutM); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total_cnt++; if (dm_bus.dm_req !== 1'b1) $display("FAIL rst_reissue_req: got %0b want 1", dm_bus.dm_req); else pass_cnt++;
    total_cnt++; if (dm_bus.dm_addr !== 32'h104) $display("FAIL rst_reissue_addr: got %h want 00000104", dm_bus.dm_addr); else pass_cnt++;
    dm_bus.dm_ack = 1'b1;
    @(negedge clk);
    dm_bus.dm_ack = 1'b0;
    total_cnt++; if (DMoutM !== 32'hCAFE_F00D) $display("FAIL rst_reissue_data: got %h want cafef00d", DMoutM); else pass_cnt++;
    instrM = 32'h0;
    @(negedge clk);
    $display("txn lw reissued after reset data=%h", DMoutM);
  endtask

  task automatic test_back_to_back();
    set_inst(T_SW, 32'h10, 32'h1111_1111);
    @(negedge clk);
    dm_bus.dm_ack = 1'b1;
    @(negedge clk);
    dm_bus.dm_ack = 1'b0;
    set_inst(T_SW, 32'h14, 32'h2222_2222);
    #1;
    total_cnt++; if (stallM !== 1'b0) $display("FAIL b2b_done_stall: got %0b want 0", stallM); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (stallM !== 1'b1) $display("FAIL b2b_idle_stall: got %0b want 1", stallM); else pass_cnt++;
    total_cnt++; if (dm_bus.dm_req !== 1'b0) $display("FAIL b2b_idle_req: got %0b want 0", dm_bus.dm_req); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (dm_bus.dm_req !== 1'b1) $display("FAIL b2b_req2: got %0b want 1", dm_bus.dm_req); else pass_cnt++;
    total_cnt++; if (dm_bus.dm_addr !== 32'h14) $display("FAIL b2b_addr2: got %h want 00000014", dm_bus.dm_addr); else pass_cnt++;
    total_cnt++; if (dm_bus.dm_wdata !== 32'h2222_2222) $display("FAIL b2b_wdata2: got %h want 22222222", dm_bus.dm_wdata); else pass_cnt++;
    dm_bus.dm_ack = 1'b1;
    @(negedge clk);
    dm_bus.dm_ack = 1'b0;
    total_cnt++; if (stallM !== 1'b0) $display("FAIL b2b_done2_stall: got %0b want 0", stallM); else pass_cnt++;
    instrM = 32'h0;
    @(negedge clk);
    $display("txn sw back-to-back addr=00000010,00000014");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_store_formats();
    test_addr_errors();
    test_timeout();
    test_reset_mid_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
